// File: rtl/color_freq_meter.sv
// Colour-sensor front end: steps the filter through red, green, blue, gates edge counts
// per channel and publishes one RGB frame. Define CLEAR_CHANNEL_EN to add a clear channel.
module color_freq_meter #(
  parameter int GATE_CYCLES   = 1000000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             sensor_freq,
  output logic [1:0]       scale,
  output logic [1:0]       filter,
  output logic             enf,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic             frame_valid,
  output logic             sat
`ifdef CLEAR_CHANNEL_EN
  ,
  output logic [CNT_W-1:0] clear_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, STORE} state_t;

  localparam logic [1:0] CH_RED   = 2'd0;
  localparam logic [1:0] CH_GREEN = 2'd1;
  localparam logic [1:0] CH_BLUE  = 2'd2;
`ifdef CLEAR_CHANNEL_EN
  localparam logic [1:0] CH_CLEAR = 2'd3;
  localparam logic [1:0] CH_LAST  = CH_CLEAR;
`else
  localparam logic [1:0] CH_LAST  = CH_BLUE;
`endif

  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]    SETTLE_END = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    GATE_END   = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state;
  logic [1:0]       ch;
  logic [1:0]       ch_next;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] work;
  logic             work_sat;
  logic [CNT_W-1:0] sh_red;
  logic [CNT_W-1:0] sh_green;
  logic             sat_red;
  logic             sat_green;
`ifdef CLEAR_CHANNEL_EN
  logic [CNT_W-1:0] sh_blue;
  logic             sat_blue;
`endif

  logic sync1;
  logic sync2;
  logic prev;
  logic edge_det;

  assign scale = 2'b11;

  function automatic logic [1:0] filter_code(input logic [1:0] c);
    case (c)
      CH_RED:   return 2'b00;
      CH_GREEN: return 2'b11;
      CH_BLUE:  return 2'b01;
      default:  return 2'b10;
    endcase
  endfunction

  // Two-flop synchroniser plus a previous-value register for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sensor_freq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_det = sync2 & ~prev;
  assign ch_next  = (ch == CH_LAST) ? CH_RED : ch + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= CH_RED;
      timer       <= '0;
      work        <= '0;
      work_sat    <= 1'b0;
      sh_red      <= '0;
      sh_green    <= '0;
      sat_red     <= 1'b0;
      sat_green   <= 1'b0;
`ifdef CLEAR_CHANNEL_EN
      sh_blue     <= '0;
      sat_blue    <= 1'b0;
      clear_cnt   <= '0;
`endif
      filter      <= 2'b00;
      enf         <= 1'b0;
      red_cnt     <= '0;
      green_cnt   <= '0;
      blue_cnt    <= '0;
      sat         <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (state == IDLE) begin
        ch     <= CH_RED;
        filter <= 2'b00;
        enf    <= 1'b0;
        if (run) begin
          state    <= SETTLE;
          enf      <= 1'b1;
          timer    <= '0;
          work     <= '0;
          work_sat <= 1'b0;
        end
      end else if (!run) begin
        // Abort: partial frame is dropped, published outputs keep their values.
        state  <= IDLE;
        ch     <= CH_RED;
        filter <= 2'b00;
        enf    <= 1'b0;
      end else begin
        case (state)
          SETTLE: begin
            if (timer == SETTLE_END) begin
              state <= GATE;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          GATE: begin
            if (edge_det) begin
              if (work == CNT_MAX) work_sat <= 1'b1;
              else                 work     <= work + CNT_W'(1);
            end
            if (timer == GATE_END) begin
              state <= STORE;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          STORE: begin
            // The last channel publishes straight from the working counter, in the
            // same edge that loads every output, so the frame never updates piecemeal.
            if (ch == CH_LAST) begin
              red_cnt     <= sh_red;
              green_cnt   <= sh_green;
`ifdef CLEAR_CHANNEL_EN
              blue_cnt    <= sh_blue;
              clear_cnt   <= work;
              sat         <= sat_red | sat_green | sat_blue | work_sat;
`else
              blue_cnt    <= work;
              sat         <= sat_red | sat_green | work_sat;
`endif
              frame_valid <= 1'b1;
            end else begin
              case (ch)
                CH_RED: begin
                  sh_red  <= work;
                  sat_red <= work_sat;
                end
                CH_GREEN: begin
                  sh_green  <= work;
                  sat_green <= work_sat;
                end
`ifdef CLEAR_CHANNEL_EN
                CH_BLUE: begin
                  sh_blue  <= work;
                  sat_blue <= work_sat;
                end
`endif
                default: ;
              endcase
            end
            ch       <= ch_next;
            filter   <= filter_code(ch_next);
            state    <= SETTLE;
            timer    <= '0;
            work     <= '0;
            work_sat <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/color_freq_meter.md
Name: color_freq_meter

Overview:
- Upstream front end for the colour classifier.
- Drives the colour sensor's scale, filter-select and enable pins, and synchronises the sensor's square-wave output.
- Counts rising edges over a fixed gate window for each filter in turn (red, green, blue).
- Publishes one coherent RGB count frame with a single-cycle valid strobe for the classifier to consume.

Parameters:
- GATE_CYCLES, 1000000, clk cycles per counting window (10 ms at 100 MHz); must be >= 1.
- SETTLE_CYCLES, 1000, clk cycles discarded after each filter change; must be >= 1.
- CNT_W, 16, width of each channel edge counter and output count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = measure continuously, 0 = idle.
- sensor_freq  in  1  raw sensor output, asynchronous to clk.
- scale  out  2  sensor frequency scaling; constant 2'b11.
- filter  out  2  filter select: 00 red, 11 green, 01 blue, 10 clear.
- enf  out  1  sensor enable; 1 while not IDLE.
- red_cnt  out  CNT_W  edge count for the last completed red window.
- green_cnt  out  CNT_W  edge count for the last completed green window.
- blue_cnt  out  CNT_W  edge count for the last completed blue window.
- frame_valid  out  1  one-cycle pulse when the count outputs update.
- sat  out  1  1 if any channel saturated in the last published frame.

Behaviour:
- Reset (async, rst=1): state IDLE; all counts 0; sat=0; frame_valid=0; filter=00; enf=0. scale is 2'b11 at all times, including during reset.
- Input conditioning:
  - sensor_freq passes through a 2-flop synchroniser, then a previous-value register.
  - edge = sync2 & ~prev.
  - Synchroniser state also clears on rst.
- State machine: states IDLE, SETTLE, GATE, STORE; channel pointer ch cycles RED -> GREEN -> BLUE -> RED.
  - IDLE: enf=0. When run=1, next cycle goes to SETTLE with ch=RED and filter=00.
  - SETTLE: lasts exactly SETTLE_CYCLES cycles; edges are ignored. The working counter is cleared on entry.
  - GATE: lasts exactly GATE_CYCLES cycles. Each cycle with edge=1 increments the working counter, including an edge in the final GATE cycle.
  - STORE: lasts 1 cycle. Copies the working counter to the shadow register for ch, then advances ch and updates filter in the same cycle. Goes to SETTLE, or, after BLUE, to SETTLE for RED.
- Frame publication:
  - Happens on the clock edge leaving BLUE STORE.
  - red_cnt, green_cnt and blue_cnt load together from the shadow registers.
  - sat loads the OR of the three per-channel saturation flags.
  - frame_valid is 1 for exactly the following cycle.
  - The outputs never update piecemeal.
- Frame period is 3*(SETTLE_CYCLES+GATE_CYCLES+1) cycles. The first frame_valid comes 1+3*(SETTLE_CYCLES+GATE_CYCLES+1) cycles after run rises in IDLE.
- Saturation: the working counter stops at 2^CNT_W-1 and never wraps. The per-channel sat flag is set on an edge while at the maximum value.
- run=0 in any non-IDLE state: next cycle goes to IDLE; the partial frame is discarded; published outputs hold their previous values; frame_valid is not asserted. This also holds when run falls during BLUE STORE.
- rst mid-operation: immediate return to reset values; no frame_valid.
- Simultaneous edge and end of GATE: the edge is counted.

Optional Feature:
- Macro: CLEAR_CHANNEL_EN.
- When defined:
  - A fourth channel CLEAR (filter 10) is inserted after BLUE, giving the sequence R, G, B, C.
  - Output port clear_cnt [CNT_W-1:0] is added, with reset value 0.
  - Publication occurs on leaving CLEAR STORE.
  - Frame period becomes 4*(SETTLE_CYCLES+GATE_CYCLES+1).
  - sat also ORs the clear channel's flag.
- When undefined: three channels only; clear_cnt does not exist; filter never takes the value 10.

Test Plan (GATE_CYCLES=100, SETTLE_CYCLES=4, CNT_W=8 unless noted):
- Reset: hold rst=1 with run=1 and a toggling sensor -> all counts 0, enf=0, filter=00, scale=11, frame_valid=0; after release, the first frame_valid occurs exactly 1+3*105 cycles after run is sampled.
- Steady tone: sensor period 10 cycles -> red/green/blue_cnt each in [9,11] on every frame_valid; filter sequence 00,11,01 with 105-cycle dwell per channel.
- Distinct tones: periods 5/10/20 during red/green/blue gates -> counts ~20/~10/~5 (±1); sat=0.
- Saturation (GATE_CYCLES=600): sensor period 2 cycles -> all counts 255, sat=1; next frame at period 10 -> sat=0, counts ~60.
- Abort: drop run during the GREEN GATE -> IDLE next cycle, enf=0, no frame_valid, previous counts held; raising run restarts at RED.
- Async reset mid-GATE: pulse rst between clock edges -> outputs clear immediately, with no frame_valid afterwards until a full new frame completes.
